// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with active-low request/grant, a per-grant hold
// limit, synchronous enable and asynchronous active-low reset.
module rr_arbiter8 #(
    parameter int unsigned MAXHOLD = 16
) (
    input  logic       CLK,
    input  logic       RST_L,
    input  logic       EN,
    input  logic [7:0] REQL,
    output logic [7:0] GNTL,
    output logic [2:0] GID,
    output logic       GVALID
);

    localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_ptr, w_ptr_nxt;
    logic [2:0]  r_gid, w_gid_nxt;
    logic [7:0]  r_hcnt, w_hcnt_nxt;
    logic [7:0]  r_gntl, w_gntl_nxt;
    logic        r_gvalid, w_gvalid_nxt;

    logic [7:0]  w_req;
    logic [15:0] w_dbl;
    logic [7:0]  w_rot;
    logic [2:0]  w_off;
    logic [2:0]  w_win;
    logic        w_any;
    logic        w_arb;

    assign w_req = ~REQL;

    // Rotate requests so bit 0 is the requester named by the pointer, then
    // the lowest set bit is the winner's offset from the pointer.
    assign w_dbl = {w_req, w_req} >> r_ptr;
    assign w_rot = w_dbl[7:0];

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (w_rot[i] && !w_any) begin
                w_any = 1'b1;
                w_off = 3'(i);
            end
        end
    end

    assign w_win = r_ptr + w_off;

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_hcnt_nxt   = r_hcnt;
        w_gid_nxt    = r_gid;
        w_gvalid_nxt = r_gvalid;
        w_arb        = 1'b0;

        if (!EN) begin
            w_state_nxt  = S_IDLE;
            w_gid_nxt    = '0;
            w_gvalid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  w_arb = 1'b1;
                S_GRANT: begin
                    if (w_req[r_gid] && (r_hcnt < HOLD_LAST))
                        w_hcnt_nxt = r_hcnt + 8'd1;
                    else
                        w_arb = 1'b1;
                end
                default: w_arb = 1'b1;
            endcase

            if (w_arb) begin
                if (w_any) begin
                    w_state_nxt  = S_GRANT;
                    w_gid_nxt    = w_win;
                    w_gvalid_nxt = 1'b1;
                    w_ptr_nxt    = w_win + 3'd1;
                    w_hcnt_nxt   = '0;
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_gid_nxt    = '0;
                    w_gvalid_nxt = 1'b0;
                end
            end
        end

        w_gntl_nxt = w_gvalid_nxt ? ~(8'd1 << w_gid_nxt) : 8'hFF;
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_hcnt   <= '0;
            r_gid    <= '0;
            r_gvalid <= 1'b0;
            r_gntl   <= '1;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_gid    <= w_gid_nxt;
            r_gvalid <= w_gvalid_nxt;
            r_gntl   <= w_gntl_nxt;
        end
    end

    assign GNTL   = r_gntl;
    assign GID    = r_gid;
    assign GVALID = r_gvalid;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: three instances (MAXHOLD 16, 1, 4) share stimulus and
// are checked every cycle against a behavioural model plus literal expectations.
module tb_rr_arbiter8;

    logic            CLK;
    logic            RST_L;
    logic            EN;
    logic [7:0]      REQL;
    logic [2:0][7:0] d_gntl;
    logic [2:0][2:0] d_gid;
    logic [2:0]      d_gvalid;

    int n_pass  = 0;
    int n_total = 0;

    int unsigned maxh [3] = '{16, 1, 4};

    // Model state per instance: owner valid, owner id, pointer, cycles held.
    logic       m_valid [3];
    logic [2:0] m_gid   [3];
    int         m_ptr   [3];
    int         m_held  [3];

    rr_arbiter8 #(.MAXHOLD(16)) u0 (
        .CLK(CLK), .RST_L(RST_L), .EN(EN), .REQL(REQL),
        .GNTL(d_gntl[0]), .GID(d_gid[0]), .GVALID(d_gvalid[0]));
    rr_arbiter8 #(.MAXHOLD(1)) u1 (
        .CLK(CLK), .RST_L(RST_L), .EN(EN), .REQL(REQL),
        .GNTL(d_gntl[1]), .GID(d_gid[1]), .GVALID(d_gvalid[1]));
    rr_arbiter8 #(.MAXHOLD(4)) u2 (
        .CLK(CLK), .RST_L(RST_L), .EN(EN), .REQL(REQL),
        .GNTL(d_gntl[2]), .GID(d_gid[2]), .GVALID(d_gvalid[2]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            for (int k = 0; k < 3; k++) begin
                m_valid[k] <= 1'b0;
                m_gid[k]   <= 3'd0;
                m_ptr[k]   <= 0;
                m_held[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                automatic bit keep;
                automatic int win;
                if (!EN) begin
                    m_valid[k] <= 1'b0;
                    m_gid[k]   <= 3'd0;
                end else begin
                    keep = m_valid[k] && (REQL[m_gid[k]] == 1'b0) &&
                           (m_held[k] + 1 < int'(maxh[k]));
                    if (keep) begin
                        m_held[k] <= m_held[k] + 1;
                    end else begin
                        win = -1;
                        for (int j = 0; j < 8; j++)
                            if (win < 0 && REQL[(m_ptr[k] + j) % 8] == 1'b0)
                                win = (m_ptr[k] + j) % 8;
                        if (win >= 0) begin
                            m_valid[k] <= 1'b1;
                            m_gid[k]   <= 3'(win);
                            m_ptr[k]   <= (win + 1) % 8;
                            m_held[k]  <= 0;
                        end else begin
                            m_valid[k] <= 1'b0;
                            m_gid[k]   <= 3'd0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            automatic logic [7:0] e_gntl = m_valid[k] ? ~(8'h01 << m_gid[k]) : 8'hFF;
            automatic logic [2:0] e_gid  = m_valid[k] ? m_gid[k] : 3'd0;
            n_total++;
            if (d_gntl[k] === e_gntl && d_gid[k] === e_gid && d_gvalid[k] === m_valid[k])
                n_pass++;
            else
                $display("FAIL model[u%0d] t=%0t: got GNTL=%h GID=%0d GVALID=%b, need GNTL=%h GID=%0d GVALID=%b",
                         k, $time, d_gntl[k], d_gid[k], d_gvalid[k], e_gntl, e_gid, m_valid[k]);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, need %h", name, act, exp);
    endtask

    // Inputs change right after a falling edge; outputs are read at the next one.
    task automatic step(input logic en, input logic [7:0] req);
        EN   = en;
        REQL = req;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_L = 1'b0;
        EN    = 1'b0;
        REQL  = 8'hFF;
        @(negedge CLK);
        RST_L = 1'b1;
    endtask

    initial begin
        RST_L = 1'b0;
        EN    = 1'b0;
        REQL  = 8'hFF;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_gntl",   d_gntl[0], 8'hFF);
        chk("reset_gid",    {5'd0, d_gid[0]}, 8'd0);
        chk("reset_gvalid", {7'd0, d_gvalid[0]}, 8'd0);
        RST_L = 1'b1;

        // Single request and release
        step(1'b1, 8'hFB);
        chk("single_gntl", d_gntl[0], 8'hFB);
        chk("single_gid",  {5'd0, d_gid[0]}, 8'd2);
        chk("single_gv",   {7'd0, d_gvalid[0]}, 8'd1);
        step(1'b1, 8'hFF);
        chk("release_gntl", d_gntl[0], 8'hFF);

        // MAXHOLD=1 rotates through all requesters
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'h00);
            chk($sformatf("rr_gid_%0d", i), {5'd0, d_gid[1]}, 8'(i % 8));
        end

        // MAXHOLD=4 timeout between two requesters
        do_reset();
        for (int c = 0; c < 9; c++) begin
            step(1'b1, 8'hFC);
            chk($sformatf("timeout_gid_%0d", c), {5'd0, d_gid[2]}, 8'((c / 4) % 2));
        end

        // Sole requester is re-granted across timeouts
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 8'h7F);
            chk($sformatf("sole_gntl_%0d", c), d_gntl[2], 8'h7F);
        end

        // Handover on release with no idle cycle; non-owner change ignored
        do_reset();
        step(1'b1, 8'hFE);
        chk("hand_own0", {5'd0, d_gid[0]}, 8'd0);
        step(1'b1, 8'hFC);
        chk("hand_hold", {5'd0, d_gid[0]}, 8'd0);
        step(1'b1, 8'hFD);
        chk("hand_gntl", d_gntl[0], 8'hFD);

        // Enable drop preserves pointer
        do_reset();
        step(1'b1, 8'hF7);
        chk("en_gid3", {5'd0, d_gid[0]}, 8'd3);
        step(1'b0, 8'hF7);
        chk("en_off_gntl", d_gntl[0], 8'hFF);
        step(1'b1, 8'hE7);
        chk("en_on_gid4", {5'd0, d_gid[0]}, 8'd4);

        // Asynchronous reset mid-grant
        do_reset();
        step(1'b1, 8'hDF);
        chk("ar_gid5", {5'd0, d_gid[0]}, 8'd5);
        #2;
        RST_L = 1'b0;
        #1;
        chk("ar_gntl_u0", d_gntl[0], 8'hFF);
        chk("ar_gntl_u2", d_gntl[2], 8'hFF);
        chk("ar_gv_u0",   {7'd0, d_gvalid[0]}, 8'd0);
        @(negedge CLK);
        RST_L = 1'b1;
        step(1'b1, 8'h00);
        chk("ar_first_gid", {5'd0, d_gid[0]}, 8'd0);
        step(1'b1, 8'hFF);
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
